// File: rtl/data_cache_refill.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_cache_refill                                            |
// | Description : Data-cache line refill engine. Accepts a miss, invalidates   |
// |               the target set entry, fetches the whole line with one AXI    |
// |               INCR burst, writes each beat into the data bank and finally  |
// |               rewrites the tag/valid entry (valid only if the burst was    |
// |               clean), then pulses refill_done.                             |
// | Ports       : clk/resetn              clock, async active-low reset        |
// |               miss_req/miss_addr/     miss request handshake               |
// |               miss_ready                                                   |
// |               ar* / r*                AXI read-address and read-data       |
// |               data_*                  data-bank word write port            |
// |               tagv_*                  tag/valid RAM write port             |
// |               refill_done/refill_err  completion pulse and status          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module data_cache_refill #(
  parameter int INDEX_W  = 7,
  parameter int TAG_W    = 20,
  parameter int OFFSET_W = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  miss_req,
  input  logic [31:0]           miss_addr,
  output logic                  miss_ready,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [3:0]            arid,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  output logic                  data_wen,
  output logic [INDEX_W-1:0]    data_index,
  output logic [OFFSET_W-3:0]   data_offset,
  output logic [31:0]           data_wdata,
  output logic                  tagv_wen,
  output logic [INDEX_W-1:0]    tagv_index,
  output logic [TAG_W-1:0]      tagv_tag,
  output logic                  tagv_valid,
  output logic                  refill_done,
  output logic                  refill_err
);

  localparam int LINE_WORDS = 1 << (OFFSET_W - 2);
  localparam int CNT_W      = OFFSET_W - 2;
  localparam int LINE_W     = 32 - OFFSET_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INVAL = 3'd1,
    AR    = 3'd2,
    R     = 3'd3,
    TAGW  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state_q;
  logic [LINE_W-1:0]   line_q;   // line address: tag, index and any bits between
  logic [CNT_W-1:0]    cnt_q;    // beat counter, also the word offset in the line
  logic                err_q;    // sticky burst error

  logic [INDEX_W-1:0]  index_w;
  logic [TAG_W-1:0]    tag_w;
  logic                last_cnt_w;
  logic                unused_w;

  assign index_w    = line_q[INDEX_W-1:0];
  assign tag_w      = line_q[LINE_W-1 -: TAG_W];
  assign last_cnt_w = (cnt_q == CNT_W'(LINE_WORDS - 1));
  // Byte-offset bits never matter: the whole line is fetched.
  assign unused_w   = ^miss_addr[OFFSET_W-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      line_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_req) begin
            line_q  <= miss_addr[31:OFFSET_W];
            cnt_q   <= '0;
            err_q   <= 1'b0;
            state_q <= INVAL;
          end
        end
        INVAL: state_q <= AR;
        AR: begin
          if (arready) state_q <= R;
        end
        R: begin
          if (rvalid) begin
            cnt_q <= cnt_q + 1'b1;
            // Bad response, or rlast not coinciding with the final word.
            if ((rresp != 2'b00) || (rlast != last_cnt_w)) err_q <= 1'b1;
            if (rlast) state_q <= TAGW;
          end
        end
        TAGW:    state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // All outputs are decoded from the state register; payloads are forced
  // to zero outside the cycles that qualify them.
  assign miss_ready  = (state_q == IDLE);

  assign arvalid     = (state_q == AR);
  assign araddr      = arvalid ? {line_q, {OFFSET_W{1'b0}}} : 32'd0;
  assign arlen       = arvalid ? 8'(LINE_WORDS - 1) : 8'd0;
  assign arsize      = arvalid ? 3'd2 : 3'd0;
  assign arburst     = arvalid ? 2'b01 : 2'b00;
  assign arid        = 4'd0;

  assign rready      = (state_q == R);
  assign data_wen    = rready & rvalid;
  assign data_index  = data_wen ? index_w : '0;
  assign data_offset = data_wen ? cnt_q : '0;
  assign data_wdata  = data_wen ? rdata : 32'd0;

  assign tagv_wen    = (state_q == INVAL) || (state_q == TAGW);
  assign tagv_index  = tagv_wen ? index_w : '0;
  assign tagv_tag    = tagv_wen ? tag_w : '0;
  assign tagv_valid  = (state_q == TAGW) & ~err_q;

  assign refill_done = (state_q == DONE);
  assign refill_err  = (state_q == DONE) & err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_cache_refill.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_data_cache_refill                                         |
// | Description : Self-checking bench for data_cache_refill. A table of        |
// |               directed refills plus randomized refills, each checked cycle |
// |               by cycle against a transaction-level model of the refill.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_data_cache_refill;

  localparam int INDEX_W  = 7;
  localparam int TAG_W    = 20;
  localparam int OFFSET_W = 5;
  localparam int LW       = 1 << (OFFSET_W - 2);
  localparam logic [125:0] RST_VEC = {1'b1, 125'd0};

  logic                clk = 1'b0;
  logic                resetn;
  logic                miss_req;
  logic [31:0]         miss_addr;
  logic                miss_ready;
  logic                arvalid, arready;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [3:0]          arid;
  logic                rvalid, rready;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                data_wen;
  logic [INDEX_W-1:0]  data_index;
  logic [OFFSET_W-3:0] data_offset;
  logic [31:0]         data_wdata;
  logic                tagv_wen;
  logic [INDEX_W-1:0]  tagv_index;
  logic [TAG_W-1:0]    tagv_tag;
  logic                tagv_valid;
  logic                refill_done, refill_err;

  data_cache_refill #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .OFFSET_W(OFFSET_W)) dut (
    .clk(clk), .resetn(resetn),
    .miss_req(miss_req), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .data_wen(data_wen), .data_index(data_index), .data_offset(data_offset),
    .data_wdata(data_wdata),
    .tagv_wen(tagv_wen), .tagv_index(tagv_index), .tagv_tag(tagv_tag),
    .tagv_valid(tagv_valid),
    .refill_done(refill_done), .refill_err(refill_err)
  );

  always #5 clk = ~clk;

  wire [125:0] outs = {miss_ready, arvalid, araddr, arlen, arsize, arburst, arid,
                       rready, data_wen, data_index, data_offset, data_wdata,
                       tagv_wen, tagv_index, tagv_tag, tagv_valid,
                       refill_done, refill_err};

  typedef struct {
    logic [31:0]        addr;
    int                 ar_delay;   // cycles arready stays low while arvalid
    bit                 gap;        // rvalid only on every other R cycle
    int                 err_beat;   // beat carrying SLVERR, -1 for none
    int                 last_beat;  // beat carrying rlast
    logic [31:0]        base;       // beat k carries base + k
    logic [31:0]        exp_araddr;
    logic [TAG_W-1:0]   exp_tag;
    logic [INDEX_W-1:0] exp_idx;
    bit                 exp_err;
    int                 exp_lat;    // cycles from acceptance to refill_done
  } vec_t;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: expected results straight from the refill rules.
  function automatic vec_t make_vec(input logic [31:0] a, input int d, input bit g,
                                    input int eb, input int lb, input logic [31:0] base);
    vec_t v;
    v.addr       = a;
    v.ar_delay   = d;
    v.gap        = g;
    v.err_beat   = eb;
    v.last_beat  = lb;
    v.base       = base;
    v.exp_araddr = (a >> OFFSET_W) << OFFSET_W;
    v.exp_tag    = TAG_W'(a >> (32 - TAG_W));
    v.exp_idx    = INDEX_W'((a >> OFFSET_W) % (1 << INDEX_W));
    v.exp_err    = ((eb >= 0) && (eb <= lb)) || (lb != LW - 1);
    v.exp_lat    = d + 4 + (g ? 2 : 1) * (lb + 1);
    return v;
  endfunction

  // Runs one refill. abort_beat >= 0 pulls resetn low while that beat is on the bus.
  task automatic run_refill(input vec_t v, input int abort_beat);
    int  n = 0, beat = 0, ar_seen = 0, r_cyc = 0;
    bit  ar_hs = 0, tw_done = 0, dn = 0, aborted = 0;
    bit  exp_ar, exp_r, exp_tw, exp_dn;
    @(posedge clk); #1;
    miss_req = 1'b1; miss_addr = v.addr; arready = 1'b0; rvalid = 1'b0;
    @(negedge clk);
    check("miss_ready_idle", miss_ready, 1'b1);
    @(posedge clk);
    while (!dn && n < 400) begin
      n++;
      #1;
      // Requests while busy must be ignored.
      miss_req  = 1'($urandom_range(0, 1));
      miss_addr = $urandom;
      arready   = (ar_seen >= v.ar_delay);
      rvalid    = v.gap ? (r_cyc % 2 == 1) : 1'b1;
      rdata     = rvalid ? v.base + 32'(beat) : $urandom;
      rresp     = rvalid ? ((beat == v.err_beat) ? 2'b10 : 2'b00) : 2'($urandom_range(0, 3));
      rlast     = rvalid ? (beat == v.last_beat) : 1'($urandom_range(0, 1));
      @(negedge clk);
      exp_ar = (n >= 2) && !ar_hs;
      exp_r  = ar_hs && (beat <= v.last_beat);
      exp_tw = (n == 1) || (ar_hs && (beat > v.last_beat) && !tw_done);
      exp_dn = tw_done && !dn;
      check("ctrl", {miss_ready, arvalid, rready, data_wen, tagv_wen, refill_done, refill_err},
            {1'b0, exp_ar, exp_r, exp_r && rvalid, exp_tw, exp_dn, exp_dn && v.exp_err});
      if (exp_ar)
        check("ar_payload", {araddr, arlen, arsize, arburst, arid},
              {v.exp_araddr, 8'(LW - 1), 3'd2, 2'b01, 4'd0});
      if (exp_tw)
        check(n == 1 ? "tagv_inval" : "tagv_final", {tagv_index, tagv_tag, tagv_valid},
              {v.exp_idx, v.exp_tag, (n == 1) ? 1'b0 : !v.exp_err});
      if (exp_r && rvalid)
        check("data_write", {data_index, data_offset, data_wdata},
              {v.exp_idx, 3'(beat % LW), v.base + 32'(beat)});
      if (exp_dn)
        check("latency", n, v.exp_lat);
      if (abort_beat >= 0 && exp_r && rvalid && beat == abort_beat) begin
        resetn = 1'b0;
        #1;
        check("reset_mid_burst_outs", outs, RST_VEC);
        repeat (2) begin
          @(posedge clk);
          @(negedge clk);
          check("held_in_reset", outs, RST_VEC);
        end
        resetn = 1'b1;
        aborted = 1;
        break;
      end
      if (exp_ar) begin
        if (arready) ar_hs = 1;
        else ar_seen++;
      end
      if (exp_r) begin
        if (rvalid) beat++;
        r_cyc++;
      end
      if (exp_tw && n != 1) tw_done = 1;
      if (exp_dn) dn = 1;
      if (!dn) @(posedge clk);
    end
    miss_req = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    if (!aborted) begin
      check("done_seen", dn, 1'b1);
      @(posedge clk);
      @(negedge clk);
      check("idle_after_done", outs, RST_VEC);
    end
  endtask

  vec_t vecs [6];
  vec_t rv;
  int   eb, lb;

  initial begin
    resetn = 1'b0; miss_req = 1'b0; miss_addr = 32'd0; arready = 1'b0;
    rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0;

    //        addr          dly gap  err last  base          araddr        tag       idx    err  lat
    vecs[0] = '{32'h1234_5670, 0, 1'b0, -1, 7, 32'h0000_00A0, 32'h1234_5660, 20'h12345, 7'h33, 1'b0, 12};
    vecs[1] = '{32'hDEAD_BEEF, 5, 1'b0, -1, 7, 32'h0000_0100, 32'hDEAD_BEE0, 20'hDEADB, 7'h77, 1'b0, 17};
    vecs[2] = '{32'h0000_0FE4, 0, 1'b1, -1, 7, 32'h5000_0000, 32'h0000_0FE0, 20'h00000, 7'h7F, 1'b0, 20};
    vecs[3] = '{32'h8000_0020, 0, 1'b0,  3, 7, 32'h0000_0300, 32'h8000_0020, 20'h80000, 7'h01, 1'b1, 12};
    vecs[4] = '{32'h5555_5555, 0, 1'b0, -1, 5, 32'h0000_0500, 32'h5555_5540, 20'h55555, 7'h2A, 1'b1, 10};
    vecs[5] = '{32'hFFFF_FFFF, 1, 1'b0, -1, 9, 32'hCAFE_0000, 32'hFFFF_FFE0, 20'hFFFFF, 7'h7F, 1'b1, 15};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", outs, RST_VEC);
    resetn = 1'b1;

    for (int i = 0; i < 6; i++) run_refill(vecs[i], -1);

    // Reset during beat 4, then a fresh refill must start cleanly at offset 0.
    run_refill(vecs[1], 4);
    run_refill(vecs[0], -1);

    for (int i = 0; i < 20; i++) begin
      eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      lb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : LW - 1;
      rv = make_vec($urandom, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                    eb, lb, $urandom);
      run_refill(rv, ($urandom_range(0, 7) == 0 && lb >= 2) ? 1 : -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
